// File: rtl/mod_arb.sv
// Purpose : round-robin arbiter/sequencer sharing one 8-bit datapath among four
//           requesters, tagging each byte with its requester ID for return routing.
// Latency : o_ack combinational; o_dp_in +1 cycle; o_rsp_* LATENCY+2 cycles after transfer.
// Backpr. : i_drain blocks new grants; responses have no backpressure and must be taken.
//
// Ports:
//   clk, rst_x            clock, asynchronous active-low reset
//   i_req[3:0]            per-requester request; i_data[8n+7:8n] is requester n's byte
//   o_ack[3:0]            one-hot grant; a transfer happens when i_req[n] & o_ack[n]
//   i_drain               level; while high no grants are issued
//   o_idle                no tag in flight, no response pending, no transfer this cycle
//   o_dp_in / i_dp_out    datapath input byte / datapath result byte
//   o_rsp_valid[3:0]      one-hot, one-cycle result strobe; o_rsp_data holds the byte
module mod_arb #(
  parameter int LATENCY = 2  // datapath cycles from i_in sample to o_out, 1..8
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic [3:0]  i_req,
  input  logic [31:0] i_data,
  output logic [3:0]  o_ack,
  input  logic        i_drain,
  output logic        o_idle,
  output logic [7:0]  o_dp_in,
  input  logic [7:0]  i_dp_out,
  output logic [3:0]  o_rsp_valid,
  output logic [7:0]  o_rsp_data
);

  typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_grant_en;
  logic [1:0]            r_rr_ptr;
  logic                  w_gnt_any;
  logic [1:0]            w_gnt_id;
  logic                  w_xfer;
  logic [7:0]            r_dp_in;
  logic [LATENCY:0]      r_tag_vld;
  logic [LATENCY:0][1:0] r_tag_id;
  logic [3:0]            r_rsp_valid;
  logic [7:0]            r_rsp_data;

  // State register
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and grant enable. i_drain is looked at combinationally in both
  // states: a rising drain suppresses the grant in its own cycle, a falling
  // drain allows a grant in its own cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (i_drain) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_grant_en = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!i_drain) begin
          w_state_nxt = S_RUN;
          w_grant_en  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // Priority scan starting just after the last winner, wrapping mod 4.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_gnt_any && i_req[r_rr_ptr + 2'(k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = r_rr_ptr + 2'(k);
      end
    end
  end

  assign o_ack  = (w_grant_en && w_gnt_any) ? (4'b0001 << w_gnt_id) : 4'b0000;
  assign w_xfer = |(i_req & o_ack);

  // Pointer, datapath input and tag pipeline. Tags shift every cycle with no
  // stall, so tag stage LATENCY lines up with the datapath result.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_rr_ptr  <= 2'd3;
      r_dp_in   <= 8'h00;
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      if (w_xfer) begin
        r_rr_ptr <= w_gnt_id;
        r_dp_in  <= i_data[8*w_gnt_id +: 8];
      end else begin
        r_dp_in  <= 8'h00;
      end
      r_tag_vld <= {r_tag_vld[LATENCY-1:0], w_xfer};
      r_tag_id  <= {r_tag_id[LATENCY-1:0], w_gnt_id};
    end
  end

  // Response register: data holds between results, strobe is a single pulse.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_rsp_valid <= 4'b0000;
      r_rsp_data  <= 8'h00;
    end else if (r_tag_vld[LATENCY]) begin
      r_rsp_valid <= 4'b0001 << r_tag_id[LATENCY];
      r_rsp_data  <= i_dp_out;
    end else begin
      r_rsp_valid <= 4'b0000;
    end
  end

  assign o_dp_in     = r_dp_in;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_idle      = ~|r_tag_vld & ~|r_rsp_valid & ~w_xfer;

endmodule
